decode_issue_pipe: RTL and testbench
====================================

Name: decode_issue_pipe

Overview:
- Parametrised successor to the decode/register-select stage.
- Carries a decoded instruction bundle through DEPTH pipeline stages (EX, MEM, WB, ...), in place of hand-chained per-signal latches.
- Adds an internal destination-register scoreboard, so RAW-hazard detection and pipeline stall are produced inside the block.
- Sits between decode logic / register file (upstream) and ALU, memory and write-back (downstream).

Parameters:
- XLEN, 32, data width of operands and immediate.
- DEPTH, 3, number of stages after decode (stage 1 = EX, stage DEPTH = WB); legal range 2..8.
- RA_W, 5, register address width.
- CTRL_W, 16, width of opaque control bundle (func, jump, mem, ld_code bits).
- CNT_W, 16, width of hazard stall counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decode holds an instruction
- in_ctrl  in  CTRL_W  decoded control bundle
- in_rd  in  RA_W  destination register
- in_rd_wr  in  1  instruction writes in_rd
- in_rs1, in_rs2  in  RA_W  source registers
- in_rs1_used, in_rs2_used  in  1  source actually read
- in_op1, in_op2, in_imm  in  XLEN  operands (op2 already imm-muxed) and immediate
- stall_ext  in  1  freeze whole pipe
- squash  in  1  kill instruction currently in decode
- flush  in  1  invalidate all stages
- in_ready  out  1  decode instruction accepted this cycle
- hazard  out  1  RAW hazard detected
- st_valid  out  DEPTH  per-stage valid, bit k-1 = stage k
- st_ctrl  out  DEPTH*CTRL_W  per-stage control, stage k in slice k-1
- st_rd  out  DEPTH*RA_W  per-stage destination
- st_rd_wr  out  DEPTH  per-stage write enable, already ANDed with valid
- ex_op1, ex_op2  out  XLEN  stage-1 operands
- st_imm  out  DEPTH*XLEN  per-stage immediate
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset: all stage registers, st_*, ex_* and stall_cnt = 0. The hazard and in_ready outputs are combinational; after reset they evaluate with all stages invalid.
- Bubble: all fields zero, valid = 0. A bubble never matches in the scoreboard.
- hazard:
  - Asserted when in_valid & ~squash and, for some stage k in 1..DEPTH-1, st_valid[k] & st_rd_wr[k] & st_rd[k] != 0 & st_rd[k] matches (in_rs1 & in_rs1_used) or (in_rs2 & in_rs2_used).
  - Stage DEPTH is excluded: the register file writes through.
- in_ready = ~stall_ext & ~hazard & ~flush.
- Each rising edge, priority order:
  1. rst: as Reset.
  2. flush: all st_valid cleared and all fields zeroed, even when stall_ext = 1.
  3. stall_ext: all stages hold.
  4. hazard: stages 2..DEPTH advance; a bubble enters stage 1.
  5. Otherwise: all stages shift; stage 1 loads the decode bundle, or a bubble if ~in_valid or squash.
- Latency: an accepted instruction appears at stage k exactly k cycles after acceptance, absent stalls.
- squash suppresses hazard; a squashed instruction never stalls the pipe.
- stall_cnt:
  - Increments on each edge where hazard & ~stall_ext & ~flush & ~rst.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst.
- Match on r0 never raises hazard; rd_wr with rd = 0 is carried but ignored by the scoreboard.

Optional Feature:
- Macro DECODE_ISSUE_FWD_EN.
- Defined:
  - Adds outputs fwd_sel1, fwd_sel2 (width $clog2(DEPTH+1)): index of the youngest matching stage, 0 = no match.
  - hazard is raised only when the matching stage-1 instruction has ctrl bit 0 (is_load) set; all other matches are forwarded.
- Undefined: ports absent; any match in stages 1..DEPTH-1 stalls, as above.

Test Plan:
- Reset, then inject add x3 with op1=5, op2=7 -> st_valid = 001, ex_op1 = 5, ex_op2 = 7 after 1 cycle; stage-3 st_rd = 3 after 3 cycles; stall_cnt = 0.
- Write x3, then immediately read rs1 = 3 (FWD off) -> hazard for 2 cycles, 2 bubbles in stage 1, in_ready low for 2 cycles, stall_cnt = 2, consumer enters stage 1 on the 3rd cycle.
- Same sequence with rd = 0 -> no hazard, back-to-back issue.
- squash = 1 while hazardous instruction in decode -> hazard = 0, bubble enters stage 1, stall_cnt unchanged.
- stall_ext = 1 for 4 cycles with 3 valid stages -> all stage outputs constant; then flush with stall_ext = 1 -> st_valid = 000 next edge.
- With DECODE_ISSUE_FWD_EN: load to x5 then use x5 -> 1 hazard cycle, then fwd_sel1 = 2; ALU op to x5 then use -> no stall, fwd_sel1 = 1.

Source files
------------

// File: rtl/decode_issue_pipe.sv
// decode_issue_pipe: decode/issue stage carrying a decoded instruction bundle
// through DEPTH stages (stage 1 = EX ... stage DEPTH = WB), with a destination
// scoreboard that produces the RAW hazard and the issue stall internally.
// Optional feature macro: DECODE_ISSUE_FWD_EN (adds fwd_sel1/fwd_sel2; only a
// load in stage 1 stalls, every other match is forwarded).
module decode_issue_pipe #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 3,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [RA_W-1:0]          in_rd,
  input  logic                     in_rd_wr,
  input  logic [RA_W-1:0]          in_rs1,
  input  logic [RA_W-1:0]          in_rs2,
  input  logic                     in_rs1_used,
  input  logic                     in_rs2_used,
  input  logic [XLEN-1:0]          in_op1,
  input  logic [XLEN-1:0]          in_op2,
  input  logic [XLEN-1:0]          in_imm,
  input  logic                     stall_ext,
  input  logic                     squash,
  input  logic                     flush,
  output logic                     in_ready,
  output logic                     hazard,
`ifdef DECODE_ISSUE_FWD_EN
  output logic [$clog2(DEPTH+1)-1:0] fwd_sel1,
  output logic [$clog2(DEPTH+1)-1:0] fwd_sel2,
`endif
  output logic [DEPTH-1:0]         st_valid,
  output logic [DEPTH*CTRL_W-1:0]  st_ctrl,
  output logic [DEPTH*RA_W-1:0]    st_rd,
  output logic [DEPTH-1:0]         st_rd_wr,
  output logic [XLEN-1:0]          ex_op1,
  output logic [XLEN-1:0]          ex_op2,
  output logic [DEPTH*XLEN-1:0]    st_imm,
  output logic [CNT_W-1:0]         stall_cnt
);

  // Stages checked by the scoreboard; stage DEPTH writes through the regfile.
  localparam int unsigned NCHK = DEPTH - 1;

  logic [DEPTH-1:0]             v_q;
  logic [DEPTH-1:0]             wr_q;
  logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q;
  logic [DEPTH-1:0][RA_W-1:0]   rd_q;
  logic [DEPTH-1:0][XLEN-1:0]   imm_q;
  logic [XLEN-1:0]              op1_q;
  logic [XLEN-1:0]              op2_q;

  logic [DEPTH-1:0] m1;
  logic [DEPTH-1:0] m2;
  logic             issue;
  logic             load;

  // Scoreboard: per-stage source match; bubbles and r0 writers never match.
  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int unsigned k = 0; k < NCHK; k++) begin
      if (v_q[k] && wr_q[k] && (rd_q[k] != '0)) begin
        m1[k] = in_rs1_used && (in_rs1 == rd_q[k]);
        m2[k] = in_rs2_used && (in_rs2 == rd_q[k]);
      end
    end
  end

  assign issue = in_valid & ~squash;

`ifdef DECODE_ISSUE_FWD_EN
  localparam int unsigned SW = $clog2(DEPTH+1);

  // Stage 1 is the youngest, so only a load sitting there cannot be forwarded.
  assign hazard = issue & (m1[0] | m2[0]) & ctrl_q[0][0];

  // Forward select: youngest matching stage wins (scan oldest to youngest).
  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    for (int unsigned j = 0; j < NCHK; j++) begin
      if (m1[NCHK-1-j]) fwd_sel1 = SW'(NCHK - j);
      if (m2[NCHK-1-j]) fwd_sel2 = SW'(NCHK - j);
    end
  end
`else
  assign hazard = issue & ((|m1) | (|m2));
`endif

  assign in_ready = ~stall_ext & ~hazard & ~flush;
  assign load     = issue & ~hazard;

  // Pipeline registers: flush beats stall_ext; hazard/squash inject a bubble.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v_q    <= '0;
      wr_q   <= '0;
      ctrl_q <= '0;
      rd_q   <= '0;
      imm_q  <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
    end else if (!stall_ext) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        v_q[k]    <= v_q[k-1];
        wr_q[k]   <= wr_q[k-1];
        ctrl_q[k] <= ctrl_q[k-1];
        rd_q[k]   <= rd_q[k-1];
        imm_q[k]  <= imm_q[k-1];
      end
      v_q[0]    <= load;
      wr_q[0]   <= load & in_rd_wr;
      ctrl_q[0] <= load ? in_ctrl : '0;
      rd_q[0]   <= load ? in_rd   : '0;
      imm_q[0]  <= load ? in_imm  : '0;
      op1_q     <= load ? in_op1  : '0;
      op2_q     <= load ? in_op2  : '0;
    end
  end

  // Saturating count of cycles lost to RAW hazards; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (hazard && !stall_ext && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign st_valid = v_q;
  assign st_rd_wr = wr_q & v_q;
  assign st_ctrl  = ctrl_q;
  assign st_rd    = rd_q;
  assign st_imm   = imm_q;
  assign ex_op1   = op1_q;
  assign ex_op2   = op2_q;

endmodule

// File: tb/tb_decode_issue_pipe.sv
// Self-checking bench for decode_issue_pipe (default build, DEPTH = 3).
module tb_decode_issue_pipe;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 3;
  localparam int RA_W   = 5;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 16;

  typedef struct {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [RA_W-1:0]   rd;
    logic              rd_wr;
    logic [RA_W-1:0]   rs1;
    logic              u1;
    logic [RA_W-1:0]   rs2;
    logic              u2;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   imm;
  } ins_t;

  typedef struct {
    ins_t             ins;
    logic             sx;
    logic             sq;
    logic             fl;
    logic             eh;
    logic             er;
    logic [DEPTH-1:0] ev;
    logic [CNT_W-1:0] ec;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_rd_wr, in_rs1_used, in_rs2_used;
  logic [CTRL_W-1:0] in_ctrl;
  logic [RA_W-1:0] in_rd, in_rs1, in_rs2;
  logic [XLEN-1:0] in_op1, in_op2, in_imm;
  logic stall_ext, squash, flush;
  logic in_ready, hazard;
  logic [DEPTH-1:0] st_valid, st_rd_wr;
  logic [DEPTH*CTRL_W-1:0] st_ctrl;
  logic [DEPTH*RA_W-1:0] st_rd;
  logic [XLEN-1:0] ex_op1, ex_op2;
  logic [DEPTH*XLEN-1:0] st_imm;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  decode_issue_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .RA_W(RA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_rd(in_rd),
    .in_rd_wr(in_rd_wr), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_used(in_rs1_used),
    .in_rs2_used(in_rs2_used), .in_op1(in_op1), .in_op2(in_op2), .in_imm(in_imm),
    .stall_ext(stall_ext), .squash(squash), .flush(flush), .in_ready(in_ready),
    .hazard(hazard), .st_valid(st_valid), .st_ctrl(st_ctrl), .st_rd(st_rd),
    .st_rd_wr(st_rd_wr), .ex_op1(ex_op1), .ex_op2(ex_op2), .st_imm(st_imm),
    .stall_cnt(stall_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: the pipe as a list of in-flight instructions, index 0 = EX.
  ins_t ms[DEPTH];
  logic [CNT_W-1:0] m_cnt;

  function automatic ins_t mk(input logic v, input int rd, input logic wr, input int rs1,
                              input logic u1, input int rs2, input logic u2,
                              input int op1, input int op2, input int imm, input int ctrl);
    ins_t x;
    x.valid = v;  x.rd = RA_W'(rd);   x.rd_wr = wr;
    x.rs1 = RA_W'(rs1); x.u1 = u1; x.rs2 = RA_W'(rs2); x.u2 = u2;
    x.op1 = XLEN'(op1); x.op2 = XLEN'(op2); x.imm = XLEN'(imm); x.ctrl = CTRL_W'(ctrl);
    return x;
  endfunction

  function automatic ins_t bubble();
    return mk(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 0, 0, 0);
  endfunction

  // A source read conflicts with any pending non-r0 write that is not yet in WB.
  function automatic bit m_hazard(input ins_t x, input bit sq);
    bit h = 0;
    if (!x.valid || sq) return 0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (ms[k].valid && ms[k].rd_wr && ms[k].rd != 0) begin
        if (x.u1 && x.rs1 == ms[k].rd) h = 1;
        if (x.u2 && x.rs2 == ms[k].rd) h = 1;
      end
    end
    return h;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) ms[k] = bubble();
    m_cnt = '0;
  endtask

  task automatic compare_all();
    logic [DEPTH-1:0] ev, ew;
    logic [DEPTH*CTRL_W-1:0] ec;
    logic [DEPTH*RA_W-1:0] er;
    logic [DEPTH*XLEN-1:0] ei;
    for (int k = 0; k < DEPTH; k++) begin
      ev[k] = ms[k].valid;
      ew[k] = ms[k].valid & ms[k].rd_wr;
      ec[k*CTRL_W +: CTRL_W] = ms[k].ctrl;
      er[k*RA_W +: RA_W] = ms[k].rd;
      ei[k*XLEN +: XLEN] = ms[k].imm;
    end
    chk("st_valid", 128'(st_valid), 128'(ev));
    chk("st_rd_wr", 128'(st_rd_wr), 128'(ew));
    chk("st_ctrl", 128'(st_ctrl), 128'(ec));
    chk("st_rd", 128'(st_rd), 128'(er));
    chk("st_imm", 128'(st_imm), 128'(ei));
    chk("ex_op1", 128'(ex_op1), 128'(ms[0].op1));
    chk("ex_op2", 128'(ex_op2), 128'(ms[0].op2));
    chk("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
  endtask

  task automatic drive(input ins_t x, input logic sx, input logic sq, input logic fl);
    in_valid = x.valid; in_ctrl = x.ctrl; in_rd = x.rd; in_rd_wr = x.rd_wr;
    in_rs1 = x.rs1; in_rs1_used = x.u1; in_rs2 = x.rs2; in_rs2_used = x.u2;
    in_op1 = x.op1; in_op2 = x.op2; in_imm = x.imm;
    stall_ext = sx; squash = sq; flush = fl;
  endtask

  // One clock: check combinational outputs, clock, advance model, check state.
  task automatic cycle(input ins_t x, input logic sx, input logic sq, input logic fl,
                       output logic h_s, output logic r_s);
    bit h;
    drive(x, sx, sq, fl);
    #1;
    h = m_hazard(x, sq);
    h_s = hazard;
    r_s = in_ready;
    chk("hazard", 128'(hazard), 128'(h));
    chk("in_ready", 128'(in_ready), 128'(!sx && !h && !fl));
    @(posedge clk);
    if (fl) begin
      for (int k = 0; k < DEPTH; k++) ms[k] = bubble();
    end else if (!sx) begin
      if (h && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
      for (int k = DEPTH - 1; k > 0; k--) ms[k] = ms[k-1];
      ms[0] = (h || !x.valid || sq) ? bubble() : x;
      if (!ms[0].valid) ms[0] = bubble();
    end
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    drive(bubble(), 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    compare_all();
    #1;
    chk("reset_hazard", 128'(hazard), 128'(0));
    chk("reset_ready", 128'(in_ready), 128'(1));
  endtask

  vec_t tbl[10];
  logic hs, rs;
  ins_t rx;

  initial begin
    // Hazard / r0 / squash sequence, expectations worked out by hand.
    tbl[0] = '{mk(1, 3, 1, 1, 1, 2, 1, 1, 2, 0, 1),  0, 0, 0, 0, 1, 3'b001, 0};
    tbl[1] = '{mk(1, 4, 1, 3, 1, 0, 0, 0, 0, 0, 2),  0, 0, 0, 1, 0, 3'b010, 1};
    tbl[2] = '{mk(1, 4, 1, 3, 1, 0, 0, 0, 0, 0, 2),  0, 0, 0, 1, 0, 3'b100, 2};
    tbl[3] = '{mk(1, 4, 1, 3, 1, 0, 0, 0, 0, 0, 2),  0, 0, 0, 0, 1, 3'b001, 2};
    tbl[4] = '{bubble(),                             0, 0, 0, 0, 1, 3'b010, 2};
    tbl[5] = '{mk(1, 0, 1, 1, 1, 2, 1, 0, 0, 0, 3),  0, 0, 0, 0, 1, 3'b101, 2};
    tbl[6] = '{mk(1, 6, 1, 0, 1, 0, 0, 0, 0, 0, 4),  0, 0, 0, 0, 1, 3'b011, 2};
    tbl[7] = '{mk(1, 9, 1, 6, 1, 0, 0, 0, 0, 0, 5),  0, 1, 0, 0, 1, 3'b110, 2};
    tbl[8] = '{mk(1, 9, 1, 6, 1, 0, 0, 0, 0, 0, 5),  0, 0, 0, 1, 0, 3'b100, 3};
    tbl[9] = '{mk(1, 9, 1, 6, 1, 0, 0, 0, 0, 0, 5),  0, 0, 0, 0, 1, 3'b001, 3};

    do_reset();

    // Single add x3: operands in EX after one edge, rd in WB after three.
    cycle(mk(1, 3, 1, 1, 1, 2, 1, 5, 7, 'h11, 'h20), 0, 0, 0, hs, rs);
    chk("add_valid", 128'(st_valid), 128'(3'b001));
    chk("add_op1", 128'(ex_op1), 128'(5));
    chk("add_op2", 128'(ex_op2), 128'(7));
    cycle(bubble(), 0, 0, 0, hs, rs);
    cycle(bubble(), 0, 0, 0, hs, rs);
    chk("add_wb_rd", 128'(st_rd[3*RA_W-1 -: RA_W]), 128'(3));
    chk("add_wb_valid", 128'(st_valid), 128'(3'b100));
    chk("add_cnt", 128'(stall_cnt), 128'(0));

    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].ins, tbl[i].sx, tbl[i].sq, tbl[i].fl, hs, rs);
      chk($sformatf("tbl%0d_hazard", i), 128'(hs), 128'(tbl[i].eh));
      chk($sformatf("tbl%0d_ready", i), 128'(rs), 128'(tbl[i].er));
      chk($sformatf("tbl%0d_valid", i), 128'(st_valid), 128'(tbl[i].ev));
      chk($sformatf("tbl%0d_cnt", i), 128'(stall_cnt), 128'(tbl[i].ec));
    end

    // Fill all three stages, freeze with a hazardous instruction waiting, then flush.
    cycle(mk(1, 10, 1, 0, 0, 0, 0, 1, 1, 'ha, 6), 0, 0, 0, hs, rs);
    cycle(mk(1, 11, 1, 0, 0, 0, 0, 2, 2, 'hb, 7), 0, 0, 0, hs, rs);
    chk("fill_valid", 128'(st_valid), 128'(3'b111));
    for (int i = 0; i < 4; i++) begin
      cycle(mk(1, 12, 1, 11, 1, 0, 0, 3, 3, 'hc, 8), 1, 0, 0, hs, rs);
      chk($sformatf("stall%0d_valid", i), 128'(st_valid), 128'(3'b111));
      chk($sformatf("stall%0d_rd", i), 128'(st_rd), 128'({5'd9, 5'd10, 5'd11}));
      chk($sformatf("stall%0d_cnt", i), 128'(stall_cnt), 128'(3));
    end
    cycle(mk(1, 12, 1, 11, 1, 0, 0, 3, 3, 'hc, 8), 1, 0, 1, hs, rs);
    chk("flush_valid", 128'(st_valid), 128'(3'b000));
    chk("flush_cnt", 128'(stall_cnt), 128'(3));

    // Random traffic on a small register set to provoke frequent conflicts.
    for (int i = 0; i < 400; i++) begin
      rx = mk(($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom_range(0, 65535));
      cycle(rx, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 19) == 0), hs, rs);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
